rate_detector: RTL
==================

RATE_DETECTOR -- requirements
Module: rate_detector

Interface
REQ-001 The block SHALL have these ports: ClockIn  input  1  sole clock, all logic on rising edge.
REQ-002 The block SHALL have these ports: Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have these ports: PulseIn  input  1  synchronous per-cycle enable; each ClockIn cycle sampled high is one event.
REQ-004 The block SHALL have these ports: Speed  output  2  recovered speed code (00 = every cycle, 01 = 500, 10 = 1000, 11 = 2000 cycles per event).
REQ-005 The block SHALL have these ports: Valid  output  1  high while Speed is locked.
REQ-006 The block SHALL have these ports: Error  output  1  one-cycle pulse on an unclassifiable interval, class change or timeout.
REQ-007 The block SHALL have these ports: Interval  output  12  last measured event-to-event interval, in ClockIn cycles.

Function
REQ-008 The block SHALL keep a 12-bit counter Cnt that clears to 0 on each event and otherwise increments, saturating at 4095.
REQ-009 On each event after the first, the measured interval SHALL equal Cnt+1, and that value SHALL be registered into Interval on the same edge.
REQ-010 The block SHALL classify intervals as 1→00, 500→01, 1000→10, 2000→11; any other interval SHALL be unclassified.
REQ-011 The FSM SHALL have exactly four states: IDLE, FIRST, ACQUIRE and LOCKED.
REQ-012 IDLE: on an event the FSM SHALL go to FIRST and clear Cnt.
REQ-013 FIRST: a classified interval SHALL store its class as the candidate and go to ACQUIRE; an unclassified interval SHALL pulse Error and stay in FIRST.
REQ-014 ACQUIRE: an interval matching the candidate SHALL go to LOCKED and set Speed=candidate and Valid=1 on that edge.
REQ-015 ACQUIRE: a different classified interval SHALL replace the candidate and stay in ACQUIRE, with no Error; an unclassified interval SHALL pulse Error and go to FIRST.
REQ-016 LOCKED: an interval matching Speed SHALL keep Speed and Valid unchanged.
REQ-017 LOCKED: any other interval SHALL pulse Error, set Valid=0, hold Speed at its last value and go to ACQUIRE (classified interval, which becomes the candidate) or FIRST (unclassified).
REQ-018 Timeout: in FIRST, ACQUIRE or LOCKED, when Cnt==4095 and PulseIn==0 the block SHALL pulse Error, set Valid=0 and go to IDLE.
REQ-019 If an event coincides with Cnt==4095, the event SHALL take priority over the timeout and the interval SHALL be 4096, which is unclassified.
REQ-020 Outputs SHALL be registered, with one-edge latency from the sampled event to the Speed, Valid, Error and Interval update.
REQ-021 Constant PulseIn=1 SHALL lock to Speed=00 on the third consecutive high cycle, i.e. Valid rises on the edge that samples the third event.

Reset
REQ-022 Asserting Reset=0 SHALL immediately force state=IDLE, Cnt=0, candidate=00, Speed=00, Valid=0, Error=0 and Interval=0.
REQ-023 Reset asserted mid-measurement SHALL discard all partial interval and lock history; after release the next event is treated as the first.

Configuration
REQ-024 The macro RATE_DETECTOR_TOLERANCE_EN SHALL control interval matching for classes 01, 10 and 11.
REQ-025 When RATE_DETECTOR_TOLERANCE_EN is defined, classes 01, 10 and 11 SHALL each accept nominal ±2 cycles (498–502, 998–1002, 1998–2002); class 00 SHALL remain exact (interval 1).
REQ-026 When RATE_DETECTOR_TOLERANCE_EN is undefined, only the exact nominal intervals SHALL classify.

Structure
REQ-027 Package rate_detector_pkg SHALL hold the FSM state enum, the nominal interval constants (1, 500, 1000, 2000), the tolerance constant 2 and the timeout value 4095.
REQ-028 A combinational sub-module rate_classifier SHALL map a 12-bit interval to {hit, class[1:0]}, and it SHALL contain the tolerance logic selected by RATE_DETECTOR_TOLERANCE_EN.

Verification
REQ-029 Events every 500 cycles, 3 events → Valid=1 and Speed=01 one edge after the 3rd event; Interval=500.
REQ-030 Locked at Speed=10 (1000-cycle events), then one interval of 2000 → Error pulses once and Valid=0 with Speed held at 10; the next 2000 interval → Valid=1, Speed=11.
REQ-031 Locked at Speed=01, then no events for 4095 cycles → Error pulse and Valid=0, then state IDLE; the next event re-enters FIRST.
REQ-032 Events at intervals of 500 then 501 → without the macro, Error pulses and the FSM enters FIRST; with the macro, Valid=1 and Speed=01.
REQ-033 PulseIn held at 1 from reset release → Valid=1 and Speed=00 after the 3rd high cycle; PulseIn then held at 0 → Error pulses at Cnt==4095.
REQ-034 Reset=0 asserted while in ACQUIRE → all outputs zero immediately; after release, 2 intervals of 1000 are required before Valid=1.

Source files
------------

// File: rtl/rate_detector_pkg.sv
// Shared types and constants for the rate detector: FSM states, nominal
// event intervals, matching tolerance and the counter timeout value.
package rate_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRST   = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  localparam int          CNT_W   = 12;
  localparam logic [11:0] NOM_C0  = 12'd1;
  localparam logic [11:0] NOM_C1  = 12'd500;
  localparam logic [11:0] NOM_C2  = 12'd1000;
  localparam logic [11:0] NOM_C3  = 12'd2000;
  localparam logic [11:0] TOL     = 12'd2;
  localparam logic [11:0] TIMEOUT = 12'd4095;

  function automatic logic near(input logic [11:0] iv, input logic [11:0] nom,
                                input logic [11:0] tol);
    return (iv >= nom - tol) && (iv <= nom + tol);
  endfunction

endpackage

// File: rtl/rate_classifier.sv
// Maps a measured interval to {hit, class}. Macro RATE_DETECTOR_TOLERANCE_EN
// widens classes 01/10/11 to nominal +/-2; class 00 is always exact.
module rate_classifier
  import rate_detector_pkg::*;
(
  input  logic [CNT_W-1:0] i_interval,
  output logic             o_hit,
  output logic [1:0]       o_class
);

`ifdef RATE_DETECTOR_TOLERANCE_EN
  localparam logic [11:0] TOL_EFF = TOL;
`else
  localparam logic [11:0] TOL_EFF = 12'd0;
`endif

  always_comb begin
    o_hit   = 1'b1;
    o_class = 2'b00;
    if (i_interval == NOM_C0)                 o_class = 2'b00;
    else if (near(i_interval, NOM_C1, TOL_EFF)) o_class = 2'b01;
    else if (near(i_interval, NOM_C2, TOL_EFF)) o_class = 2'b10;
    else if (near(i_interval, NOM_C3, TOL_EFF)) o_class = 2'b11;
    else                                      o_hit   = 1'b0;
  end

endmodule

// File: rtl/rate_detector.sv
// Recovers the event rate of PulseIn and locks Speed after two matching
// intervals. Optional tolerance via RATE_DETECTOR_TOLERANCE_EN (see rate_classifier).
module rate_detector
  import rate_detector_pkg::*;
(
  input  logic              ClockIn,
  input  logic              Reset,
  input  logic              PulseIn,
  output logic [1:0]        Speed,
  output logic              Valid,
  output logic              Error,
  output logic [CNT_W-1:0]  Interval
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cand;
  logic [1:0]       r_speed;
  logic             r_valid;
  logic             r_error;
  logic [CNT_W-1:0] r_interval;

  logic [CNT_W:0]   w_iv;
  logic [CNT_W-1:0] w_iv_sat;
  logic             w_hit;
  logic [1:0]       w_cls;

  // Interval is Cnt+1; the 4096 case does not fit 12 bits and is shown as 4095
  assign w_iv     = {1'b0, r_cnt} + 13'd1;
  assign w_iv_sat = w_iv[CNT_W] ? TIMEOUT : w_iv[CNT_W-1:0];

  rate_classifier u_cls (
    .i_interval (w_iv_sat),
    .o_hit      (w_hit),
    .o_class    (w_cls)
  );

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cand     <= 2'b00;
      r_speed    <= 2'b00;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_interval <= '0;
    end else begin
      r_error <= 1'b0;
      r_cnt   <= PulseIn ? '0 : ((r_cnt == TIMEOUT) ? r_cnt : r_cnt + 12'd1);
      if (PulseIn) begin
        if (r_state == ST_IDLE) begin
          r_state <= ST_FIRST;
        end else begin
          r_interval <= w_iv_sat;
          case (r_state)
            ST_FIRST: begin
              if (w_hit) begin
                r_cand  <= w_cls;
                r_state <= ST_ACQUIRE;
              end else begin
                r_error <= 1'b1;
              end
            end
            ST_ACQUIRE: begin
              if (!w_hit) begin
                r_error <= 1'b1;
                r_state <= ST_FIRST;
              end else if (w_cls == r_cand) begin
                r_speed <= r_cand;
                r_valid <= 1'b1;
                r_state <= ST_LOCKED;
              end else begin
                r_cand <= w_cls;
              end
            end
            ST_LOCKED: begin
              // Speed holds its last value while re-acquiring
              if (!(w_hit && (w_cls == r_speed))) begin
                r_error <= 1'b1;
                r_valid <= 1'b0;
                if (w_hit) begin
                  r_cand  <= w_cls;
                  r_state <= ST_ACQUIRE;
                end else begin
                  r_state <= ST_FIRST;
                end
              end
            end
            default: ;
          endcase
        end
      end else if ((r_state != ST_IDLE) && (r_cnt == TIMEOUT)) begin
        r_error <= 1'b1;
        r_valid <= 1'b0;
        r_state <= ST_IDLE;
      end
    end
  end

  assign Speed    = r_speed;
  assign Valid    = r_valid;
  assign Error    = r_error;
  assign Interval = r_interval;

endmodule
